// File: rtl/fetch_npc_pkg.sv
// Shared fetch-stage types: state encoding, RAS entry, predecode record and
// MIPS opcode fields used to spot calls, returns and immediate jumps.
package fetch_npc_pkg;

  typedef logic [31:0] virt_t;

  localparam virt_t RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    SEQ,
    DS_REQ,
    DS_RSP
  } fetch_state_e;

  typedef struct packed {
    logic  valid;
    virt_t data;
  } ras_t;

  typedef struct packed {
    logic  is_call;
    logic  is_ret;
    logic  is_jimm;
    virt_t imm_target;
  } predecode_t;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [4:0] RT_BLTZAL  = 5'b10000;
  localparam logic [4:0] RT_BGEZAL  = 5'b10001;
  localparam logic [4:0] REG_RA     = 5'd31;

endpackage

// File: rtl/fetch_npc_predecode.sv
// Combinational predecoder: classifies an I-cache word as call, return or
// immediate jump and forms the J/JAL region target from PC+4.
module fetch_npc_predecode
  import fetch_npc_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output predecode_t  pd
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  virt_t      pc_plus4;
  logic       unused_pc_low;

  assign op       = inst[31:26];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign funct    = inst[5:0];
  assign pc_plus4 = pc + 32'd4;

  // J/JAL only replace the low 28 bits; the region comes from the delay slot PC.
  assign unused_pc_low = ^pc_plus4[27:0];

  always_comb begin
    pd            = '0;
    pd.imm_target = {pc_plus4[31:28], inst[25:0], 2'b00};
    pd.is_jimm    = (op == OP_J) || (op == OP_JAL);
    pd.is_call    = (op == OP_JAL)
                 || ((op == OP_REGIMM) && ((rt == RT_BGEZAL) || (rt == RT_BLTZAL)))
                 || ((op == OP_SPECIAL) && (funct == FN_JALR) && (rd == REG_RA));
    pd.is_ret     = (op == OP_SPECIAL) && (funct == FN_JR) && (rs == REG_RA);
  end

endmodule

// File: rtl/fetch_npc.sv
// Next-PC generator for the MIPS fetch stage: issues I-cache requests, filters
// responses against the expected path, predicts jumps/returns and tracks the delay slot.
module fetch_npc #(
  parameter fetch_npc_pkg::virt_t RESET_PC = fetch_npc_pkg::RESET_PC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [31:0]          flush_pc,
  output logic                 req_valid,
  output logic [31:0]          req_pc,
  input  logic                 req_ready,
  input  logic                 rsp_valid,
  input  logic [31:0]          rsp_pc,
  input  logic [31:0]          rsp_inst,
  output logic                 rsp_ready,
  output logic                 out_valid,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_inst,
  input  logic                 out_ready,
  output logic                 ras_push_req,
  output logic                 ras_pop_req,
  output logic [31:0]          ras_push_data,
  input  fetch_npc_pkg::ras_t  ras_top
);

  import fetch_npc_pkg::*;

  fetch_state_e state, state_nxt;
  virt_t        pc, pc_nxt;
  virt_t        exp_pc, exp_pc_nxt;
  virt_t        tgt, tgt_nxt;

  predecode_t   pd;
  logic         fire;
  logic         accept;
  logic         in_seq;
  logic         taken;
  virt_t        p_plus4;
  virt_t        pred_tgt;

  fetch_npc_predecode u_predecode (
    .inst (rsp_inst),
    .pc   (rsp_pc),
    .pd   (pd)
  );

  assign req_valid = !reset && !flush;
  assign req_pc    = pc;
  assign rsp_ready = out_ready;
  assign fire      = req_valid && req_ready;
  assign accept    = !reset && !flush && rsp_valid && out_ready && (rsp_pc == exp_pc);
  assign in_seq    = (state == SEQ);
  assign p_plus4   = rsp_pc + 32'd4;

  // A return is only predicted when the stack actually holds an entry.
  assign taken    = accept && in_seq && (pd.is_jimm || (pd.is_ret && ras_top.valid));
  assign pred_tgt = pd.is_jimm ? pd.imm_target : ras_top.data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= SEQ;
      pc     <= RESET_PC;
      exp_pc <= RESET_PC;
      tgt    <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      exp_pc <= exp_pc_nxt;
      tgt    <= tgt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    exp_pc_nxt = exp_pc;
    tgt_nxt    = tgt;
    if (flush) begin
      pc_nxt     = flush_pc;
      exp_pc_nxt = flush_pc;
      state_nxt  = SEQ;
    end else begin
      case (state)
        SEQ: begin
          if (fire)   pc_nxt     = pc + 32'd4;
          if (accept) exp_pc_nxt = p_plus4;
          if (taken) begin
            tgt_nxt = pred_tgt;
            // Delay slot not yet on its way: hold pc there until it is requested.
            if ((pc == p_plus4) && !fire) begin
              state_nxt = DS_REQ;
            end else begin
              pc_nxt    = pred_tgt;
              state_nxt = DS_RSP;
            end
          end
        end
        DS_REQ: begin
          if (fire) begin
            pc_nxt    = tgt;
            state_nxt = DS_RSP;
          end
        end
        DS_RSP: begin
          if (fire) pc_nxt = pc + 32'd4;
          if (accept) begin
            exp_pc_nxt = tgt;
            state_nxt  = SEQ;
          end
        end
        default: state_nxt = SEQ;
      endcase
    end
  end

  always_comb begin
    out_valid     = accept;
    out_pc        = rsp_pc;
    out_inst      = rsp_inst;
    ras_push_req  = accept && in_seq && pd.is_call;
    ras_pop_req   = accept && in_seq && pd.is_ret;
    ras_push_data = ras_push_req ? (rsp_pc + 32'd8) : 32'd0;
  end

endmodule

// File: doc/fetch_npc.md
Name: fetch_npc

Overview:
- Next-PC generator and predecoder for the single-issue MIPS fetch stage.
- Issues instruction-fetch addresses to the I-cache and checks I-cache responses against the expected path, dropping wrong-path responses.
- Predecodes JAL/BAL/JALR-link/JR $ra to drive the return address stack's push/pop ports, and consumes the stack's top entry for return prediction.
- Honours the MIPS branch delay slot and forwards accepted instructions to decode.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- flush  in  1  backend redirect; highest priority.
- flush_pc  in  32  redirect target.
- req_valid  out  1  fetch request valid.
- req_pc  out  32  fetch address.
- req_ready  in  1  I-cache accepts the request this cycle.
- rsp_valid  in  1  I-cache response valid; responses arrive in request order.
- rsp_pc  in  32  PC of the response.
- rsp_inst  in  32  instruction word.
- rsp_ready  out  1  equals out_ready.
- out_valid  out  1  instruction to decode.
- out_pc  out  32  PC of the instruction to decode.
- out_inst  out  32  instruction word to decode.
- out_ready  in  1  decode accepts.
- ras_push_req  out  1  push to the return address stack.
- ras_pop_req  out  1  pop from the return address stack.
- ras_push_data  out  32  link address (PC+8).
- ras_top  in  ras_t  top entry of the stack: data and valid.

Behaviour:
- Registers:
  - pc: next request address.
  - exp_pc: next PC accepted from the I-cache.
  - tgt: predicted target.
  - state: fetch_state_e, one of SEQ, DS_REQ, DS_RSP.
- Reset: pc=RESET_PC, exp_pc=RESET_PC, state=SEQ, tgt=0. During the reset cycle req_valid=0, out_valid=0 and ras_* outputs=0.
- req_valid=1 whenever reset=0 and flush=0. A request fires when req_valid && req_ready.
- Acceptance: a response is accepted when rsp_valid && rsp_ready && rsp_pc==exp_pc.
  - A response with rsp_pc!=exp_pc is dropped silently: out_valid=0, no RAS operation.
  - out_valid, out_pc and out_inst are combinational from an accepted response. Latency is 0 cycles from response to decode.
- Predecode (accepted response in SEQ state only):
  - JAL (op 000011): push PC+8; taken with tgt={PC+4[31:28], instr_index, 2'b00}.
  - BAL / BGEZAL / BLTZAL (REGIMM rt 10001/10000): push PC+8; no prediction.
  - JALR with rd=31: push PC+8; no prediction.
  - JR with rs=31: pop. Taken with tgt=ras_top.data only if ras_top.valid; otherwise no prediction.
  - J (op 000010): taken with tgt={PC+4[31:28], index, 2'b00}; no RAS operation.
  - ras_* are one-cycle combinational pulses. Push and pop are never both asserted.
- Taken prediction on accepted instruction at P (state SEQ):
  - exp_pc<=P+4 and tgt latched.
  - If pc==P+4 and no request fires this cycle with pc==P+4: state->DS_REQ.
  - Else, when pc!=P+4 or the P+4 request fires this cycle, the delay slot has already been requested: pc<=tgt, state->DS_RSP.
- DS_REQ: req_pc=P+4. When it fires: pc<=tgt, state->DS_RSP.
- DS_RSP: the accepted response is the delay slot. It is passed to decode with no predecode and no RAS operation. Then exp_pc<=tgt, state->SEQ.
- Not-taken or non-control accepted response: exp_pc<=PC+4.
- Sequential advance: when a request fires in SEQ/DS_RSP and no redirect applies, pc<=pc+4. Addresses wrap modulo 2^32.
- flush (any state, any cycle):
  - pc<=flush_pc, exp_pc<=flush_pc, state->SEQ.
  - Same cycle: req_valid=0, out_valid=0, ras_*=0.
  - In-flight responses are dropped by the exp_pc mismatch.
- reset has priority over flush.

Decomposition:
- Shared cpu package:
  - RESET_PC.
  - fetch_state_e.
  - Opcode/funct/REGIMM constants.
  - predecode_t struct {is_call, is_ret, is_jimm, imm_target}.
  - ras_t and virt_t stay in the package.
- Sub-module fetch_predecode: purely combinational rsp_inst/rsp_pc -> predecode_t.

Test Plan:
- Reset release: req_pc=BFC00000, then BFC00004 and BFC00008 with req_ready=1. Responses at matching PCs reach decode in the same cycle.
- JAL at 0xBFC00010, index=0x100, P+4 already requested: push pulse with data BFC00018. Delay slot BFC00014 forwarded. Next request 0xB0000400. Stale response BFC00018 dropped.
- JR $31 with ras_top={valid=1, data=BFC00018}: pop pulse, delay slot forwarded, exp_pc=BFC00018. With ras_top.valid=0: pop pulse, sequential fetch continues.
- Prediction accepted while req_ready=0 and pc==P+4: state DS_REQ, req_pc held at P+4 until ready, then target.
- flush with flush_pc=0x80000180 while in DS_RSP: next req_pc=80000180, state SEQ. The old delay-slot response is dropped with no RAS pulse.
- out_ready=0 with rsp_valid=1: rsp_ready=0, out_valid=0, no RAS pulse, exp_pc unchanged.
